// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  localparam int DIV_N     = 16;
  localparam int DIV_TAG_W = 5;
  localparam int ABS_W     = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // The counter must reach N, so it needs room for N+1 values.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_N);

  // Two's-complement negate when neg is set. Callers truncate to their own width.
  function automatic logic [ABS_W-1:0] abs_n(input logic [ABS_W-1:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract if it fits.
module div_step
  import div_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N:0]   rem_i,
  input  logic         dvd_msb_i,
  input  logic [N-1:0] dvs_i,
  output logic [N:0]   rem_o,
  output logic         qbit_o
);

  logic [N+1:0] shifted;
  logic [N:0]   diff;

  // rem_i < dvs_i <= 2^N-1, so the shifted value always fits in N+1 bits.
  assign shifted = {rem_i, dvd_msb_i};
  assign diff    = shifted[N:0] - {1'b0, dvs_i};
  assign qbit_o  = (shifted >= {2'b00, dvs_i});
  assign rem_o   = qbit_o ? diff : shifted[N:0];

endmodule

// File: rtl/div_seq.sv
// Sequential signed/unsigned restoring divider, one quotient bit per clock,
// with valid/ready handshakes, a pass-through tag and a pipeline flush.
module div_seq
  import div_pkg::*;
#(
  parameter int N     = 16,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [N-1:0]     in_dvd,
  input  logic [N-1:0]     in_dvs,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_quo,
  output logic [N-1:0]     out_rem,
  output logic             out_dz,
  output logic [TAG_W-1:0] out_tag,
  output div_state_t       dbg_state
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  // Handshakes: a transfer happens on an edge where valid && ready are both high.
  // in_ready is high only in IDLE; out_valid is high only in DONE and holds until
  // out_ready. flush overrides both transfers in the same cycle.

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N:0]       rem_q, rem_d;
  logic [N-1:0]     quo_q, quo_d;
  logic [N-1:0]     dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic             accept;
  logic             sign_dvd, sign_dvs;
  logic             dz_case, ovf_case;
  logic [N-1:0]     dvd_abs, dvs_abs;
  logic [N:0]       step_rem;
  logic             step_qbit;

  assign accept   = in_valid && (state_q == IDLE) && !flush;
  assign sign_dvd = in_signed && in_dvd[N-1];
  assign sign_dvs = in_signed && in_dvs[N-1];
  assign dz_case  = (in_dvs == '0);
  assign ovf_case = in_signed && (in_dvd == {1'b1, {(N-1){1'b0}}}) && (in_dvs == '1);
  assign dvd_abs  = N'(abs_n(ABS_W'(in_dvd), sign_dvd));
  assign dvs_abs  = N'(abs_n(ABS_W'(in_dvs), sign_dvs));

  // During BUSY quo_q doubles as the dividend shift register: its MSB feeds
  // the step and quotient bits enter at the LSB.
  div_step #(.N(N)) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (quo_q[N-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (dz_case || ovf_case) ? DONE : BUSY;
      BUSY:    if (cnt_q == LAST_CNT) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    tag_d  = tag_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tag_d  = in_tag;
          qneg_d = sign_dvd ^ sign_dvs;
          rneg_d = sign_dvd;
          cnt_d  = '0;
          dz_d   = 1'b0;
          rem_d  = '0;
          if (dz_case) begin
            quo_d = '1;
            rem_d = {1'b0, in_dvd};
            dz_d  = 1'b1;
          end else if (ovf_case) begin
            quo_d = in_dvd;
          end else begin
            quo_d = dvd_abs;
            dvs_d = dvs_abs;
          end
        end
      end
      BUSY: begin
        rem_d = step_rem;
        quo_d = {quo_q[N-2:0], step_qbit};
        cnt_d = cnt_q + CW'(1);
      end
      FIX: begin
        if (qneg_q) quo_d = -quo_q;
        if (rneg_q) rem_d = {1'b0, -rem_q[N-1:0]};
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_quo   = quo_q;
    out_rem   = rem_q[N-1:0];
    out_dz    = dz_q;
    out_tag   = tag_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases, flush/reset, backpressure, random ops.
module tb_div_seq;
  import div_pkg::*;

  localparam int N     = 16;
  localparam int TAG_W = 5;
  localparam int W     = 2 * N + 1 + TAG_W;
  localparam int LAT_NORMAL  = N + 1;
  localparam int LAT_SPECIAL = 0;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             in_valid, in_ready, in_signed;
  logic [N-1:0]     in_dvd, in_dvs;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid, out_ready;
  logic [N-1:0]     out_quo, out_rem;
  logic             out_dz;
  logic [TAG_W-1:0] out_tag;
  div_state_t       dbg_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  div_seq #(.N(N), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .in_dvd    (in_dvd),
    .in_dvs    (in_dvs),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_quo   (out_quo),
    .out_rem   (out_rem),
    .out_dz    (out_dz),
    .out_tag   (out_tag),
    .dbg_state (dbg_state)
  );

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] pack(input logic [N-1:0] q, input logic [N-1:0] r,
                                        input logic dz, input logic [TAG_W-1:0] tag);
    return {q, r, dz, tag};
  endfunction

  // Reference model built on integer division (truncating, remainder follows dividend).
  function automatic logic [W-1:0] model(input logic sgn, input logic [N-1:0] dvd,
                                         input logic [N-1:0] dvs, input logic [TAG_W-1:0] tag);
    logic [N-1:0] q, r;
    int a, b;
    if (dvs == '0) return pack('1, dvd, 1'b1, tag);
    if (!sgn) begin
      q = dvd / dvs;
      r = dvd % dvs;
    end else begin
      a = int'($signed(dvd));
      b = int'($signed(dvs));
      q = N'(a / b);
      r = N'(a % b);
    end
    return pack(q, r, 1'b0, tag);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver: present one operation for a single accept edge, then scramble the inputs
  task automatic send(input logic sgn, input logic [N-1:0] dvd, input logic [N-1:0] dvs,
                      input logic [TAG_W-1:0] tag, input logic [W-1:0] exp, input bit push);
    check("in_ready_before_accept", in_ready, 1);
    in_valid  = 1'b1;
    in_signed = sgn;
    in_dvd    = dvd;
    in_dvs    = dvs;
    in_tag    = tag;
    @(posedge clk);
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    in_valid  = 1'b0;
    in_signed = 1'($urandom_range(0, 1));
    in_dvd    = N'($urandom);
    in_dvs    = N'($urandom);
    in_tag    = TAG_W'($urandom);
  endtask

  task automatic wait_valid(output int edges, output bit ok);
    edges = 0;
    while (out_valid !== 1'b1 && edges < 64) begin
      @(negedge clk);
      edges++;
    end
    ok = (out_valid === 1'b1);
    check("out_valid_timeout", ok, 1);
  endtask

  // scoreboard side: wait for the result, compare, optionally stall, then accept
  task automatic recv(input string name, input int exp_lat, input int hold);
    int edges;
    bit ok;
    logic [W-1:0] e, snap;
    wait_valid(edges, ok);
    if (!ok) return;
    if (exp_lat >= 0) check({name, "_latency"}, edges, exp_lat);
    check({name, "_scoreboard_nonempty"}, (exp_q.size() > 0), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check({name, "_quo"}, out_quo, e[W-1 -: N]);
    check({name, "_rem"}, out_rem, e[W-N-1 -: N]);
    check({name, "_dz"},  out_dz,  e[TAG_W]);
    check({name, "_tag"}, out_tag, e[TAG_W-1:0]);
    snap = {out_quo, out_rem, out_dz, out_tag};
    repeat (hold) begin
      @(negedge clk);
      check({name, "_hold_stable"}, {out_quo, out_rem, out_dz, out_tag}, snap);
      check({name, "_hold_valid"}, out_valid, 1);
      check({name, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_release_valid"}, out_valid, 0);
    check({name, "_release_in_ready"}, in_ready, 1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_in_ready"},  in_ready, 1);
    check({name, "_out_valid"}, out_valid, 0);
    check({name, "_out_quo"},   out_quo, 0);
    check({name, "_out_rem"},   out_rem, 0);
    check({name, "_out_dz"},    out_dz, 0);
    check({name, "_out_tag"},   out_tag, 0);
    check({name, "_state"},     dbg_state, IDLE);
  endtask

  task automatic watch_no_valid(input string name, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    check(name, seen, 0);
  endtask

  initial begin
    logic [N-1:0] dvd, dvs;
    logic sgn;
    logic [TAG_W-1:0] tag;
    int mode, lat;
    int edges;
    bit ok;

    rst = 1'b1; in_valid = 1'b0; in_signed = 1'b0; in_dvd = '0; in_dvs = '0;
    in_tag = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1: unsigned 100/7, tag echoed
    send(1'b0, 16'd100, 16'd7, 5'h0A, pack(16'd14, 16'd2, 1'b0, 5'h0A), 1);
    recv("t1_u100_7", LAT_NORMAL, 0);

    // 2: signed operands with mixed signs
    send(1'b1, 16'hFF9C, 16'h0007, 5'h11, pack(16'hFFF2, 16'hFFFE, 1'b0, 5'h11), 1);
    recv("t2_sm100_7", LAT_NORMAL, 0);
    send(1'b1, 16'h0064, 16'hFFF9, 5'h12, pack(16'hFFF2, 16'h0002, 1'b0, 5'h12), 1);
    recv("t2_s100_m7", LAT_NORMAL, 0);

    // 3: divide by zero in both modes
    send(1'b1, 16'h1234, 16'h0000, 5'h03, pack(16'hFFFF, 16'h1234, 1'b1, 5'h03), 1);
    recv("t3_dz_signed", LAT_SPECIAL, 0);
    send(1'b0, 16'h1234, 16'h0000, 5'h04, pack(16'hFFFF, 16'h1234, 1'b1, 5'h04), 1);
    recv("t3_dz_unsigned", LAT_SPECIAL, 0);

    // 4: signed overflow, then the same bits unsigned
    send(1'b1, 16'h8000, 16'hFFFF, 5'h05, pack(16'h8000, 16'h0000, 1'b0, 5'h05), 1);
    recv("t4_ovf_signed", LAT_SPECIAL, 0);
    send(1'b0, 16'h8000, 16'hFFFF, 5'h06, pack(16'h0000, 16'h8000, 1'b0, 5'h06), 1);
    recv("t4_ovf_unsigned", LAT_NORMAL, 0);

    // 5: backpressure, then back-to-back independent ops
    send(1'b0, 16'd1000, 16'd10, 5'h07, pack(16'd100, 16'd0, 1'b0, 5'h07), 1);
    recv("t5_backpressure", LAT_NORMAL, 5);
    send(1'b0, 16'hABCD, 16'h0013, 5'h08, pack(16'h090A, 16'h000F, 1'b0, 5'h08), 1);
    recv("t5_b2b_a", LAT_NORMAL, 0);
    send(1'b1, 16'h8001, 16'h0003, 5'h09, pack(16'hD556, 16'hFFFF, 1'b0, 5'h09), 1);
    recv("t5_b2b_b", LAT_NORMAL, 0);

    // 6: flush at count 8, reset at count 3, then a clean op
    send(1'b0, 16'h1234, 16'h0005, 5'h1F, '0, 0);
    repeat (8) @(negedge clk);
    check("t6_busy_before_flush", dbg_state, BUSY);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("t6_flush_state", dbg_state, IDLE);
    check("t6_flush_valid", out_valid, 0);
    watch_no_valid("t6_flush_no_valid", 25);

    send(1'b1, 16'h7777, 16'h0003, 5'h1E, '0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("t6_rst");
    watch_no_valid("t6_rst_no_valid", 25);

    send(1'b0, 16'hFFFF, 16'h0003, 5'h02, pack(16'h5555, 16'h0000, 1'b0, 5'h02), 1);
    recv("t6_after", LAT_NORMAL, 0);

    // flush beats in_valid in IDLE
    in_valid = 1'b1; in_signed = 1'b0; in_dvd = 16'd50; in_dvs = 16'd5; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_beats_in_valid", dbg_state, IDLE);

    // flush discards a finished result waiting in DONE
    send(1'b0, 16'd77, 16'd0, 5'h01, '0, 0);
    wait_valid(edges, ok);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    check("flush_in_done_valid", out_valid, 0);
    check("flush_in_done_state", dbg_state, IDLE);

    // random operations against the reference model
    for (int i = 0; i < 2000; i++) begin
      mode = $urandom_range(0, 7);
      sgn  = 1'($urandom_range(0, 1));
      dvd  = N'($urandom);
      dvs  = N'($urandom);
      tag  = TAG_W'($urandom);
      case (mode)
        0: dvs = 16'd1;
        1: dvs = dvd;
        2: begin
          if (dvs == '0) dvs = 16'd1;
          dvd = N'($urandom_range(0, int'(dvs) - 1));
        end
        3: dvs = '0;
        4: begin dvd = 16'h8000; dvs = 16'hFFFF; end
        5: dvs = N'($urandom_range(1, 15));
        default: ;
      endcase
      lat = ((dvs == '0) || (sgn && dvd == 16'h8000 && dvs == 16'hFFFF)) ? LAT_SPECIAL : LAT_NORMAL;
      send(sgn, dvd, dvs, tag, model(sgn, dvd, dvs, tag), 1);
      recv("rnd", lat, $urandom_range(0, 2));
    end

    check("final_scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
